// File: rtl/caf_foas_loader.sv
// Transmitter side of the CAF frequency-step load: streams a symmetric offset grid of foas bins
// (magnitude + neg_shift) over valid/ready. Optional hold input under `CAF_FOAS_LOADER_HOLD_EN.
module caf_foas_loader #(
    parameter int phase_bits        = 10,
    parameter int foas              = 3,
    parameter int foas_counter_bits = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [phase_bits-1:0]        step_size,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         m_axis_freq_step_tvalid,
    output logic [phase_bits-1:0]        freq_step,
    output logic                         neg_shift,
    input  logic                         freq_step_tready,
    output logic [foas_counter_bits-1:0] freq_step_index
`ifdef CAF_FOAS_LOADER_HOLD_EN
    ,
    input  logic                         hold
`endif
);

    localparam int HALF        = (foas - 1) / 2;
    localparam int PREP_CYCLES = (HALF == 0) ? 1 : HALF;
    localparam bit GROW        = (foas > 1);

    localparam logic [foas_counter_bits-1:0] PREP_LAST = foas_counter_bits'(PREP_CYCLES);
    localparam logic [foas_counter_bits-1:0] IDX_LAST  = foas_counter_bits'(foas - 1);
    localparam logic [foas_counter_bits-1:0] CNT_ONE   = foas_counter_bits'(1);
    localparam logic [foas_counter_bits-1:0] CNT_ZERO  = '0;
    localparam logic [phase_bits-1:0]        MAG_ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t                         state_r;
    logic [phase_bits-1:0]          step_r;
    logic [phase_bits-1:0]          mag_r;
    logic                           neg_r;
    logic [foas_counter_bits-1:0]   idx_r;
    logic [foas_counter_bits-1:0]   prep_cnt_r;
    logic                           tvalid_r;
    logic                           busy_r;
    logic                           done_r;
    logic                           err_r;

    logic [phase_bits:0]            sum_s;
    logic [phase_bits-1:0]          diff_s;
    logic                           tvalid_s;
    logic                           xfer_s;

    // One extra bit on the sum exposes the grid overflow as a carry.
    function automatic logic [phase_bits:0] mag_up(input logic [phase_bits-1:0] mag,
                                                   input logic [phase_bits-1:0] step);
        return {1'b0, mag} + {1'b0, step};
    endfunction

    function automatic logic [phase_bits-1:0] mag_down(input logic [phase_bits-1:0] mag,
                                                       input logic [phase_bits-1:0] step);
        return mag - step;
    endfunction

    // Magnitude arithmetic shared by PREP growth and SEND stepping.
    always_comb begin
        sum_s  = mag_up(mag_r, step_r);
        diff_s = mag_down(mag_r, step_r);
    end

`ifdef CAF_FOAS_LOADER_HOLD_EN
    // Hold masks the registered valid, which also freezes idx/mag/neg since no transfer can occur.
    always_comb begin
        if (state_r == ST_SEND) begin
            tvalid_s = tvalid_r & ~hold;
        end else begin
            tvalid_s = tvalid_r;
        end
    end
`else
    // Valid comes straight from the FSM register.
    always_comb begin
        tvalid_s = tvalid_r;
    end
`endif

    assign xfer_s = tvalid_s & freq_step_tready;

    // Load sequencer: IDLE -> PREP (walk out to the most negative bin) -> SEND (stream bins).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            step_r     <= MAG_ZERO;
            mag_r      <= MAG_ZERO;
            neg_r      <= 1'b0;
            idx_r      <= CNT_ZERO;
            prep_cnt_r <= CNT_ZERO;
            tvalid_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        step_r     <= step_size;
                        mag_r      <= MAG_ZERO;
                        neg_r      <= 1'b0;
                        idx_r      <= CNT_ZERO;
                        prep_cnt_r <= CNT_ZERO;
                        busy_r     <= 1'b1;
                        state_r    <= ST_PREP;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    if (prep_cnt_r == PREP_LAST) begin
                        idx_r    <= CNT_ZERO;
                        neg_r    <= (mag_r != MAG_ZERO);
                        tvalid_r <= 1'b1;
                        state_r  <= ST_SEND;
                    end else if (GROW && sum_s[phase_bits]) begin
                        // Outermost magnitude does not fit: abort before any bin is shown.
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        if (GROW) begin
                            mag_r <= sum_s[phase_bits-1:0];
                        end else begin
                            mag_r <= MAG_ZERO;
                        end
                        prep_cnt_r <= prep_cnt_r + CNT_ONE;
                    end
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        if (idx_r == IDX_LAST) begin
                            tvalid_r <= 1'b0;
                            done_r   <= 1'b1;
                            busy_r   <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else begin
                            idx_r <= idx_r + CNT_ONE;
                            if (neg_r) begin
                                mag_r <= diff_s;
                                if (diff_s == MAG_ZERO) begin
                                    neg_r <= 1'b0;
                                end else begin
                                    neg_r <= 1'b1;
                                end
                            end else begin
                                mag_r <= sum_s[phase_bits-1:0];
                            end
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                default: begin
                    tvalid_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy                    = busy_r;
    assign done                    = done_r;
    assign err                     = err_r;
    assign m_axis_freq_step_tvalid = tvalid_s;
    assign freq_step               = mag_r;
    assign neg_shift               = neg_r;
    assign freq_step_index         = idx_r;

endmodule

// File: tb/tb_caf_foas_loader.sv
// Directed bench for caf_foas_loader: one instance with foas=3 and one with foas=5.
module tb_caf_foas_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start3, start5;
    logic [9:0] step3, step5;
    logic       busy3, done3, err3, tv3, neg3, ready3;
    logic       busy5, done5, err5, tv5, neg5, ready5;
    logic [9:0] fs3, fs5;
    logic [2:0] idx3, idx5;

    int checks = 0;
    int errors = 0;
    int xfer3_cnt = 0;
    int done3_cnt = 0;
    int tv5_cnt   = 0;

    caf_foas_loader #(.phase_bits(10), .foas(3), .foas_counter_bits(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .step_size(step3),
        .busy(busy3), .done(done3), .err(err3),
        .m_axis_freq_step_tvalid(tv3), .freq_step(fs3), .neg_shift(neg3),
        .freq_step_tready(ready3), .freq_step_index(idx3)
    );

    caf_foas_loader #(.phase_bits(10), .foas(5), .foas_counter_bits(3)) u5 (
        .clk(clk), .rst(rst), .start(start5), .step_size(step5),
        .busy(busy5), .done(done5), .err(err5),
        .m_axis_freq_step_tvalid(tv5), .freq_step(fs5), .neg_shift(neg5),
        .freq_step_tready(ready5), .freq_step_index(idx5)
    );

    // Event counters sampled on the active edge (pre-update values).
    always @(posedge clk) begin
        if (tv3 && ready3) xfer3_cnt <= xfer3_cnt + 1;
        if (done3)         done3_cnt <= done3_cnt + 1;
        if (tv5)           tv5_cnt   <= tv5_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp3(input string tag, input logic tv, input int fs, input logic ng, input int ix);
        check_eq({tag, ".tvalid"}, 32'(tv3), 32'(tv));
        if (tv) begin
            check_eq({tag, ".freq_step"}, 32'(fs3), 32'(fs));
            check_eq({tag, ".neg_shift"}, 32'(neg3), 32'(ng));
            check_eq({tag, ".index"}, 32'(idx3), 32'(ix));
        end
    endtask

    task automatic exp5(input string tag, input logic tv, input int fs, input logic ng, input int ix);
        check_eq({tag, ".tvalid"}, 32'(tv5), 32'(tv));
        if (tv) begin
            check_eq({tag, ".freq_step"}, 32'(fs5), 32'(fs));
            check_eq({tag, ".neg_shift"}, 32'(neg5), 32'(ng));
            check_eq({tag, ".index"}, 32'(idx5), 32'(ix));
        end
    endtask

    int base_x, base_d, base_t;

    initial begin
        rst = 1'b1; start3 = 1'b0; step3 = 10'd0; ready3 = 1'b1;
        start5 = 1'b0; step5 = 10'd0; ready5 = 1'b1;
        tick; tick;
        check_eq("rst.busy3", 32'(busy3), 32'd0);
        check_eq("rst.done3", 32'(done3), 32'd0);
        check_eq("rst.err3", 32'(err3), 32'd0);
        check_eq("rst.tv3", 32'(tv3), 32'd0);
        check_eq("rst.fs3", 32'(fs3), 32'd0);
        check_eq("rst.neg3", 32'(neg3), 32'd0);
        check_eq("rst.idx3", 32'(idx3), 32'd0);
        check_eq("rst.busy5", 32'(busy5), 32'd0);
        check_eq("rst.tv5", 32'(tv5), 32'd0);
        rst = 1'b0;
        tick;

        // foas=3, step=5, always ready
        start3 = 1'b1; step3 = 10'd5; tick; start3 = 1'b0;
        check_eq("t1.busy", 32'(busy3), 32'd1);
        exp3("t1.c0", 1'b0, 0, 1'b0, 0);
        tick; exp3("t1.c1", 1'b0, 0, 1'b0, 0);
        tick; exp3("t1.b0", 1'b1, 5, 1'b1, 0);
        tick; exp3("t1.b1", 1'b1, 0, 1'b0, 1);
        tick; exp3("t1.b2", 1'b1, 5, 1'b0, 2);
        tick; exp3("t1.end", 1'b0, 0, 1'b0, 0);
        check_eq("t1.done", 32'(done3), 32'd1);
        check_eq("t1.busy_end", 32'(busy3), 32'd0);
        tick; check_eq("t1.done_pulse", 32'(done3), 32'd0);

        // foas=5, step=100, latency of 3 cycles
        start5 = 1'b1; step5 = 10'd100; tick; start5 = 1'b0;
        exp5("t2.c0", 1'b0, 0, 1'b0, 0);
        tick; exp5("t2.c1", 1'b0, 0, 1'b0, 0);
        tick; exp5("t2.c2", 1'b0, 0, 1'b0, 0);
        tick; exp5("t2.b0", 1'b1, 200, 1'b1, 0);
        tick; exp5("t2.b1", 1'b1, 100, 1'b1, 1);
        tick; exp5("t2.b2", 1'b1, 0, 1'b0, 2);
        tick; exp5("t2.b3", 1'b1, 100, 1'b0, 3);
        tick; exp5("t2.b4", 1'b1, 200, 1'b0, 4);
        tick; exp5("t2.end", 1'b0, 0, 1'b0, 0);
        check_eq("t2.done", 32'(done5), 32'd1);
        check_eq("t2.busy_end", 32'(busy5), 32'd0);
        tick;

        // foas=3, step=7, ready low 4 cycles on bin 1
        base_x = xfer3_cnt; base_d = done3_cnt;
        start3 = 1'b1; step3 = 10'd7; tick; start3 = 1'b0;
        tick;
        tick; exp3("t3.b0", 1'b1, 7, 1'b1, 0);
        tick; exp3("t3.b1", 1'b1, 0, 1'b0, 1);
        ready3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick; exp3("t3.stall", 1'b1, 0, 1'b0, 1);
        end
        ready3 = 1'b1;
        tick; exp3("t3.b2", 1'b1, 7, 1'b0, 2);
        tick; check_eq("t3.done", 32'(done3), 32'd1);
        tick;
        check_eq("t3.xfers", 32'(xfer3_cnt - base_x), 32'd3);
        check_eq("t3.dones", 32'(done3_cnt - base_d), 32'd1);

        // foas=5, step=600: second PREP add reaches 1200 > 1023
        base_t = tv5_cnt;
        start5 = 1'b1; step5 = 10'd600; tick; start5 = 1'b0;
        check_eq("t4.err_c0", 32'(err5), 32'd0);
        tick; check_eq("t4.err_c1", 32'(err5), 32'd0);
        tick; check_eq("t4.err", 32'(err5), 32'd1);
        check_eq("t4.busy", 32'(busy5), 32'd0);
        check_eq("t4.tv", 32'(tv5), 32'd0);
        tick; check_eq("t4.err_pulse", 32'(err5), 32'd0);
        check_eq("t4.no_done", 32'(done5), 32'd0);
        check_eq("t4.never_valid", 32'(tv5_cnt - base_t), 32'd0);

        // reset after bin 1 transfer, then a clean load with step=2
        base_d = done3_cnt;
        start3 = 1'b1; step3 = 10'd9; tick; start3 = 1'b0;
        tick;
        tick; exp3("t5.b0", 1'b1, 9, 1'b1, 0);
        tick; exp3("t5.b1", 1'b1, 0, 1'b0, 1);
        tick; exp3("t5.b2", 1'b1, 9, 1'b0, 2);
        rst = 1'b1;
        tick; rst = 1'b0;
        check_eq("t5.rst_tv", 32'(tv3), 32'd0);
        check_eq("t5.rst_busy", 32'(busy3), 32'd0);
        check_eq("t5.rst_done", 32'(done3), 32'd0);
        check_eq("t5.rst_fs", 32'(fs3), 32'd0);
        check_eq("t5.rst_idx", 32'(idx3), 32'd0);
        start3 = 1'b1; step3 = 10'd2; tick; start3 = 1'b0;
        tick;
        tick; exp3("t5.n0", 1'b1, 2, 1'b1, 0);
        tick; exp3("t5.n1", 1'b1, 0, 1'b0, 1);
        tick; exp3("t5.n2", 1'b1, 2, 1'b0, 2);
        tick; check_eq("t5.done", 32'(done3), 32'd1);
        tick;
        check_eq("t5.dones", 32'(done3_cnt - base_d), 32'd1);

        // start re-pulsed during SEND with a different step is ignored
        start3 = 1'b1; step3 = 10'd4; tick; start3 = 1'b0;
        tick;
        tick; exp3("t6.b0", 1'b1, 4, 1'b1, 0);
        start3 = 1'b1; step3 = 10'd50;
        tick; start3 = 1'b0;
        exp3("t6.b1", 1'b1, 0, 1'b0, 1);
        tick; exp3("t6.b2", 1'b1, 4, 1'b0, 2);
        tick; check_eq("t6.done", 32'(done3), 32'd1);
        tick; check_eq("t6.idle", 32'(busy3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
